mem_lsu: RTL and testbench

Load/store unit: the initiator side of the core's word-wide data memory port. Accepts one load or store request at a time from the core datapath (RV32I funct3 encoding). Drives the memory's `we`, address and write-data lines. Returns sign- or zero-extended load data, and performs read-modify-write for byte and halfword stores, because the memory supports only whole-word writes.

---
 rtl/mem_lsu_pkg.sv | 30 +++
 rtl/mem_lsu_if.sv | 29 ++
 rtl/mem_lsu_lane.sv | 38 +++
 rtl/mem_lsu.sv | 97 +++++++++
 tb/tb_mem_lsu.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store unit: RV32I funct3 codes, FSM encoding,
// and the request legality check (alignment plus illegal/unsupported funct3).
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Unsigned variants have no store form, so BU/HU with we=1 are illegal.
  function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] alo);
    case (f3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = alo[0];
      F3_W:    req_err = (alo != 2'b00);
      F3_BU:   req_err = we;
      F3_HU:   req_err = we | alo[0];
      default: req_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Core request/response and word-memory signals of the load/store unit.
// slave = the LSU itself, master = the core plus memory that surround it.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              o_ready;
  logic              o_done;
  logic [31:0]       o_rdata;
  logic              o_err;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    output o_ready, o_done, o_rdata, o_err, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    input  o_ready, o_done, o_rdata, o_err, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_lsu_lane.sv
// Combinational little-endian lane logic: extracts a sign/zero-extended load value
// from a word, and merges byte/halfword store data into a word for read-modify-write.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    case (funct3_i)
      F3_B:    merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit, one request at a time; done after 1 (error), 2 (load/SW) or 3 (SB/SH) cycles.
// No backpressure beyond o_ready: requests are taken only in IDLE and sampled at acceptance.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  mem_lsu_if.slave  bus
);

  state_e            state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        alo_q;
  logic [31:0]       wd_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic              acc_err;
  logic [31:0]       load_val;
  logic [31:0]       merge_val;

  assign acc_err = req_err(bus.i_we, bus.i_funct3, bus.i_addr[1:0]);

  mem_lsu_lane u_lane (
    .word_i    (bus.i_mem_rdata),
    .wdata_i   (wd_q),
    .addr_lo_i (alo_q),
    .funct3_i  (f3_q),
    .load_o    (load_val),
    .merge_o   (merge_val)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      alo_q       <= 2'b00;
      wd_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_req) begin
            we_q  <= bus.i_we;
            f3_q  <= bus.i_funct3;
            alo_q <= bus.i_addr[1:0];
            wd_q  <= bus.i_wdata;
            err_q <= acc_err;
            if (acc_err) begin
              rdata_q <= '0;
              state_q <= ST_RESP;
            end else begin
              mem_addr_q <= {2'b00, bus.i_addr[ADDR_W-1:2]};
              // Whole-word stores skip the read; everything else reads first.
              if (bus.i_we && bus.i_funct3 == F3_W) begin
                mem_wdata_q <= bus.i_wdata;
                state_q     <= ST_WR;
              end else begin
                state_q <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (we_q) begin
            mem_wdata_q <= merge_val;
            state_q     <= ST_WR;
          end else begin
            rdata_q <= load_val;
            state_q <= ST_RESP;
          end
        end
        ST_WR:   state_q <= ST_RESP;
        ST_RESP: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write enable decodes straight from state so an async reset kills it at once.
  assign bus.o_ready     = (state_q == ST_IDLE);
  assign bus.o_done      = (state_q == ST_RESP);
  assign bus.o_mem_we    = (state_q == ST_WR);
  assign bus.o_rdata     = rdata_q;
  assign bus.o_err       = err_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases, mid-access reset, randomized
// requests against a word-array reference model, and back-to-back throughput.
module tb_mem_lsu;

  logic clk;
  logic rst_n;

  mem_lsu_if #(.ADDR_W(32)) bus ();

  mem_lsu #(.ADDR_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench memory: combinational read, write on the clock edge, plus a preload path.
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [31:0] pl_val;
  int          we_total;

  assign bus.i_mem_rdata = mem[bus.o_mem_addr[4:0]];

  always @(posedge clk) begin
    if (bus.o_mem_we === 1'b1) begin
      mem[bus.o_mem_addr[4:0]] <= bus.o_mem_wdata;
      we_total <= we_total + 1;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end
  end

  int n_cmp;
  int n_bad;

  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (int'(addr[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    logic [31:0] v;
    sz = m_size(f3);
    v = word >> (int'(addr[1:0]) * 8);
    if (sz < 4) begin
      v = v & ((32'd1 << (8 * sz)) - 32'd1);
      if (!f3[2] && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] word, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    int sh;
    logic [31:0] mask;
    sz = m_size(f3);
    sh = int'(addr[1:0]) * 8;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    return (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  function automatic int m_lat(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (m_err(we, f3, addr)) return 1;
    if (!we) return 2;
    return (m_size(f3) == 4) ? 2 : 3;
  endfunction

  // Tasks are entered just after a falling edge.
  task automatic set_word(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx[4:0];
    pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output int wes,
                        output logic [31:0] wword, output logic [31:0] rdata,
                        output logic err, output logic pulse_ok);
    int guard;
    guard = 0;
    wes = 0;
    wword = '0;
    lat = 0;
    while (bus.o_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.i_req    = 1'b1;
    bus.i_we     = we;
    bus.i_funct3 = f3;
    bus.i_addr   = addr;
    bus.i_wdata  = wd;
    @(posedge clk);
    #1;
    bus.i_req   = 1'b0;
    bus.i_wdata = $urandom;
    bus.i_addr  = $urandom;
    do begin
      @(negedge clk);
      lat++;
      if (bus.o_mem_we === 1'b1) begin
        wes++;
        wword = bus.o_mem_wdata;
      end
    end while (bus.o_done !== 1'b1 && lat < 10);
    rdata = bus.o_rdata;
    err   = bus.o_err;
    @(negedge clk);
    pulse_ok = (bus.o_done === 1'b0) && (bus.o_ready === 1'b1) && (bus.o_rdata === rdata);
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
    n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    n_cmp++; if (bus.o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.o_err); end
    n_cmp++; if (bus.o_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus.o_rdata); end
    n_cmp++; if (bus.o_mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", bus.o_mem_we); end
    n_cmp++; if (bus.o_mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", bus.o_mem_addr); end
    n_cmp++; if (bus.o_mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", bus.o_mem_wdata); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5];
    logic [31:0] ads [5];
    logic [31:0] exp [5];
    int lat, wes;
    logic [31:0] ww, rd;
    logic er, pok;
    f3s = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001};
    ads = '{32'h0C, 32'h0F, 32'h0F, 32'h0E, 32'h0C};
    exp = '{32'h8899AABB, 32'hFFFFFF88, 32'h00000088, 32'h00008899, 32'hFFFFAABB};
    set_word(3, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], ads[i], 32'h0, lat, wes, ww, rd, er, pok);
      n_cmp++; if (rd !== exp[i]) begin n_bad++; $display("FAIL load_data[%0d] got %h want %h", i, rd, exp[i]); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL load_latency[%0d] got %0d want 2", i, lat); end
      n_cmp++; if (wes !== 0 || er !== 1'b0) begin n_bad++; $display("FAIL load_we_err[%0d] got we=%0d err=%b want 0/0", i, wes, er); end
      n_cmp++; if (bus.o_mem_addr !== 32'd3) begin n_bad++; $display("FAIL load_addr[%0d] got %h want 3", i, bus.o_mem_addr); end
      n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL load_pulse[%0d] got %b want 1", i, pok); end
    end
  endtask

  task automatic test_stores();
    int lat, wes;
    logic [31:0] ww, rd;
    logic er, pok;
    do_req(1'b1, 3'b000, 32'h0D, 32'h123456EE, lat, wes, ww, rd, er, pok);
    n_cmp++; if (wes !== 1) begin n_bad++; $display("FAIL sb_we_cycles got %0d want 1", wes); end
    n_cmp++; if (ww !== 32'h8899EEBB) begin n_bad++; $display("FAIL sb_wdata got %h want 8899eebb", ww); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sb_latency got %0d want 3", lat); end
    do_req(1'b1, 3'b001, 32'h0E, 32'h0000CAFE, lat, wes, ww, rd, er, pok);
    n_cmp++; if (mem[3] !== 32'hCAFEEEBB) begin n_bad++; $display("FAIL sh_mem got %h want cafeeebb", mem[3]); end
    n_cmp++; if (lat !== 3 || wes !== 1) begin n_bad++; $display("FAIL sh_timing got lat=%0d we=%0d want 3/1", lat, wes); end
    ref_mem[3] = 32'hCAFEEEBB;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, wes, ww, rd, er, pok);
    n_cmp++; if (mem[4] !== 32'hDEADBEEF || lat !== 2 || wes !== 1) begin
      n_bad++; $display("FAIL sw got mem=%h lat=%0d we=%0d want deadbeef/2/1", mem[4], lat, wes); end
    ref_mem[4] = 32'hDEADBEEF;
  endtask

  task automatic test_errors();
    int lat, wes;
    logic [31:0] ww, rd;
    logic er, pok;
    set_word(1, 32'h01020304);
    do_req(1'b1, 3'b010, 32'h06, 32'hFFFFFFFF, lat, wes, ww, rd, er, pok);
    n_cmp++; if (er !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL sw_misaligned got err=%b lat=%0d want 1/1", er, lat); end
    n_cmp++; if (wes !== 0 || mem[1] !== 32'h01020304) begin n_bad++; $display("FAIL sw_misaligned_mem got we=%0d mem=%h want 0/01020304", wes, mem[1]); end
    do_req(1'b0, 3'b011, 32'h0C, 32'h0, lat, wes, ww, rd, er, pok);
    n_cmp++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_bad++; $display("FAIL f3_011 got err=%b lat=%0d rdata=%h want 1/1/0", er, lat, rd); end
    n_cmp++; if (wes !== 0 || pok !== 1'b1) begin n_bad++; $display("FAIL f3_011_we got we=%0d pulse=%b want 0/1", wes, pok); end
  endtask

  task automatic test_reset_mid(input int stage);
    int wes_before, dones, lat, wes;
    logic [31:0] ww, rd;
    logic er, pok;
    set_word(5, 32'hA5A5_5A5A);
    wes_before = we_total;
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = 3'b000; bus.i_addr = 32'h15; bus.i_wdata = 32'h77;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    if (stage == 2) begin
      @(posedge clk);
      #1;
      n_cmp++; if (bus.o_mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre_we got %b want 1", bus.o_mem_we); end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_mem_we !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid%0d got we=%b ready=%b done=%b want 0/1/0", stage, bus.o_mem_we, bus.o_ready, bus.o_done); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) dones++;
    end
    n_cmp++; if (dones !== 0 || mem[5] !== 32'hA5A5_5A5A || we_total !== wes_before) begin
      n_bad++; $display("FAIL rst_mid%0d_after got done=%0d mem=%h writes=%0d want 0/a5a55a5a/%0d", stage, dones, mem[5], we_total, wes_before); end
    do_req(1'b0, 3'b010, 32'h14, 32'h0, lat, wes, ww, rd, er, pok);
    n_cmp++; if (rd !== 32'hA5A5_5A5A || lat !== 2 || er !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid%0d_lw got %h lat=%0d err=%b want a5a55a5a/2/0", stage, rd, lat, er); end
  endtask

  task automatic test_random();
    int lat, wes, idx;
    logic [31:0] ww, rd, addr, wd;
    logic [2:0] f3;
    logic we, er, pok, xerr;
    for (int i = 0; i < 32; i++) set_word(i, $urandom);
    for (int n = 0; n < 80; n++) begin
      addr = 32'($urandom_range(0, 127));
      f3   = 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      idx  = int'(addr[6:2]);
      xerr = m_err(we, f3, addr);
      do_req(we, f3, addr, wd, lat, wes, ww, rd, er, pok);
      if (we && !xerr) ref_mem[idx] = m_store(ref_mem[idx], wd, f3, addr);
      n_cmp++; if (er !== xerr || lat !== m_lat(we, f3, addr) || wes !== ((we && !xerr) ? 1 : 0)) begin
        n_bad++; $display("FAIL rand[%0d] we=%b f3=%0d a=%h got err=%b lat=%0d wes=%0d want %b/%0d", n, we, f3, addr, er, lat, wes, xerr, m_lat(we, f3, addr)); end
      if (!we || xerr) begin
        n_cmp++; if (rd !== (xerr ? 32'h0 : m_load(ref_mem[idx], f3, addr))) begin
          n_bad++; $display("FAIL rand_rdata[%0d] f3=%0d a=%h got %h want %h", n, f3, addr, rd, xerr ? 32'h0 : m_load(ref_mem[idx], f3, addr)); end
      end
      n_cmp++; if (mem[idx] !== ref_mem[idx] || pok !== 1'b1) begin
        n_bad++; $display("FAIL rand_mem[%0d] got %h pulse=%b want %h/1", n, mem[idx], pok, ref_mem[idx]); end
    end
  endtask

  task automatic test_back_to_back();
    int at [3];
    int nd;
    nd = 0;
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_funct3 = 3'b010; bus.i_addr = 32'h0C;
    for (int c = 0; c < 20 && nd < 3; c++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        at[nd] = c;
        nd++;
        n_cmp++; if (bus.o_rdata !== ref_mem[3]) begin n_bad++; $display("FAIL b2b_data got %h want %h", bus.o_rdata, ref_mem[3]); end
      end
    end
    bus.i_req = 1'b0;
    n_cmp++; if (nd !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", nd); end
    else begin
      n_cmp++; if (at[1] - at[0] !== 3 || at[2] - at[1] !== 3) begin
        n_bad++; $display("FAIL b2b_period got %0d,%0d want 3,3", at[1] - at[0], at[2] - at[1]); end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    we_total = 0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_funct3 = 3'b000; bus.i_addr = '0; bus.i_wdata = '0;
    rst_n = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid(1);
    test_reset_mid(2);
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
